lz_normalizer: RTL and testbench

//  Pipelined normalizer that consumes a leading-zero count: left-shifts an operand so its MSB is 1
//  and returns the shift amount applied. It is the consumer side of leading-zero counting.

---
 rtl/lzn_pkg.sv | 25 ++
 rtl/lzn_count.sv | 38 +++
 rtl/lz_normalizer.sv | 109 ++++++++++
 tb/tb_lz_normalizer.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lzn_pkg.sv
// Shared types and widths for the leading-zero normalizer.
// LZN_DENORM_EN adds a right-shift (denormalize) payload to each op.
package lzn_pkg;

    localparam int LZN_WIDTH = 32;
    localparam int LZN_CNT_W = 6;
    localparam int LZN_TAG_W = 7;

    typedef struct packed {
        logic [LZN_WIDTH-1:0] data;
        logic [LZN_TAG_W-1:0] tag;
`ifdef LZN_DENORM_EN
        logic                 denorm;
        logic [LZN_CNT_W-1:0] shamt;
`endif
    } lzn_op_t;

    typedef struct packed {
        logic [LZN_WIDTH-1:0] data;
        logic [LZN_CNT_W-1:0] shamt;
        logic                 zero;
        logic [LZN_TAG_W-1:0] tag;
    } lzn_res_t;

endpackage

// File: rtl/lzn_count.sv
// Log-tree leading-zero counter: 2-bit leaves, pairwise merges.
// An all-zero input returns WIDTH.
module lzn_count #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] data,
    output logic [CNT_W-1:0] cnt
);

    localparam int LOG = $clog2(WIDTH);

    // Level l covers groups of 2**l bits; c holds the group's count,
    // z flags an all-zero group. Index 2i+1 is the more significant half.
    for (genvar l = 1; l <= LOG; l++) begin : g_lvl
        localparam int N = WIDTH >> l;
        logic [l-1:0] c [N];
        logic [N-1:0] z;
        for (genvar i = 0; i < N; i++) begin : g_node
            if (l == 1) begin : g_leaf
                assign c[i] = ~data[2*i+1];
                assign z[i] = ~|data[2*i+1 -: 2];
            end else begin : g_merge
                logic zh;
                logic zl;
                assign zh = g_lvl[l-1].z[2*i+1];
                assign zl = g_lvl[l-1].z[2*i];
                assign z[i] = zh & zl;
                assign c[i] = zh ? {1'b1, g_lvl[l-1].c[2*i]}
                                 : {1'b0, g_lvl[l-1].c[2*i+1]};
            end
        end
    end

    assign cnt = g_lvl[LOG].z[0] ? CNT_W'(WIDTH)
                                 : CNT_W'({1'b0, g_lvl[LOG].c[0]});

endmodule

// File: rtl/lz_normalizer.sv
// Two-stage normalizer: S1 registers operand + LZC, S2 registers the shift.
// Optional LZN_DENORM_EN adds logical right-shift ops by a given amount.
module lz_normalizer
    import lzn_pkg::*;
#(
    parameter int WIDTH = LZN_WIDTH,
    parameter int CNT_W = $clog2(WIDTH) + 1,
    parameter int TAG_W = LZN_TAG_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IN_flush,
    input  logic             IN_valid,
    output logic             IN_ready,
    input  logic [WIDTH-1:0] IN_data,
    input  logic [TAG_W-1:0] IN_tag,
`ifdef LZN_DENORM_EN
    input  logic             IN_denorm,
    input  logic [CNT_W-1:0] IN_shamt,
`endif
    output logic             OUT_valid,
    input  logic             OUT_ready,
    output logic [WIDTH-1:0] OUT_data,
    output logic [CNT_W-1:0] OUT_shamt,
    output logic             OUT_zero,
    output logic [TAG_W-1:0] OUT_tag
);

    lzn_op_t          op_in;
    lzn_op_t          s1_q;
    logic             s1_valid;
    logic [CNT_W-1:0] s1_cnt;
    logic [CNT_W-1:0] lzc;
    lzn_res_t         s2_d;
    lzn_res_t         s2_q;
    logic             s2_valid;
    logic             s1_adv;

    lzn_count #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) u_count (
        .data(IN_data),
        .cnt (lzc)
    );

    // Combinational ready chain: S1 frees up whenever S2 can take its op.
    assign s1_adv   = !s2_valid || OUT_ready;
    assign IN_ready = !s1_valid || s1_adv;

    always_comb begin
        op_in      = '0;
        op_in.data = IN_data;
        op_in.tag  = IN_tag;
`ifdef LZN_DENORM_EN
        op_in.denorm = IN_denorm;
        op_in.shamt  = IN_shamt;
`endif
    end

    always_comb begin
        s2_d       = '0;
        s2_d.tag   = s1_q.tag;
        s2_d.data  = s1_q.data << s1_cnt;
        s2_d.shamt = s1_cnt;
        s2_d.zero  = (s1_cnt == CNT_W'(WIDTH));
`ifdef LZN_DENORM_EN
        if (s1_q.denorm) begin
            s2_d.data  = s1_q.data >> s1_q.shamt;
            s2_d.shamt = s1_q.shamt;
            s2_d.zero  = ~|(s1_q.data >> s1_q.shamt);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
            s1_cnt   <= '0;
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (IN_flush) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else begin
            if (s1_adv) begin
                s2_valid <= s1_valid;
                if (s1_valid) begin
                    s2_q <= s2_d;
                end
            end
            if (IN_ready) begin
                s1_valid <= IN_valid;
                if (IN_valid) begin
                    s1_q   <= op_in;
                    s1_cnt <= lzc;
                end
            end
        end
    end

    assign OUT_valid = s2_valid;
    assign OUT_data  = s2_q.data;
    assign OUT_shamt = s2_q.shamt;
    assign OUT_zero  = s2_q.zero;
    assign OUT_tag   = s2_q.tag;

endmodule

// File: tb/tb_lz_normalizer.sv
// Self-checking bench for lz_normalizer: directed table, stall/flush/reset
// sequences and a random stream against a scoreboard model.
module tb_lz_normalizer;

    logic        clk = 1'b0;
    logic        rst;
    logic        IN_flush;
    logic        IN_valid;
    logic        IN_ready;
    logic [31:0] IN_data;
    logic [6:0]  IN_tag;
    logic        IN_denorm;
    logic [5:0]  IN_shamt;
    logic        OUT_valid;
    logic        OUT_ready;
    logic [31:0] OUT_data;
    logic [5:0]  OUT_shamt;
    logic        OUT_zero;
    logic [6:0]  OUT_tag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    lz_normalizer dut (
        .clk      (clk),
        .rst      (rst),
        .IN_flush (IN_flush),
        .IN_valid (IN_valid),
        .IN_ready (IN_ready),
        .IN_data  (IN_data),
        .IN_tag   (IN_tag),
`ifdef LZN_DENORM_EN
        .IN_denorm(IN_denorm),
        .IN_shamt (IN_shamt),
`endif
        .OUT_valid(OUT_valid),
        .OUT_ready(OUT_ready),
        .OUT_data (OUT_data),
        .OUT_shamt(OUT_shamt),
        .OUT_zero (OUT_zero),
        .OUT_tag  (OUT_tag)
    );

    typedef struct {
        logic [31:0] d;
        int          sh;
        bit          z;
        logic [6:0]  tag;
    } exp_t;

    typedef struct {
        logic [31:0] d;
        logic [6:0]  t;
        bit          dn;
        int          ds;
        logic [31:0] ed;
        int          es;
        bit          ez;
    } vec_t;

    exp_t        q[$];
    exp_t        e;
    vec_t        vt[$];
    bit          prev_stall = 0;
    logic [45:0] prev_out;
    bit          accepted;
    logic [45:0] snap;

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Leading zeros found by scanning from the MSB.
    function automatic exp_t model(input logic [31:0] d, input logic [6:0] t,
                                   input bit dn, input int ds);
        exp_t r;
        r.tag = t;
        if (dn) begin
            r.d  = (ds >= 32) ? 32'h0 : d >> ds;
            r.sh = ds;
            r.z  = (r.d == 0);
        end else begin
            r.sh = 32;
            for (int i = 0; i < 32; i++)
                if (r.sh == 32 && d[31-i]) r.sh = i;
            r.d = (r.sh == 32) ? 32'h0 : d << r.sh;
            r.z = (d == 0);
        end
        return r;
    endfunction

    function automatic logic [31:0] rnd_data();
        int          lz = $urandom_range(0, 32);
        logic [31:0] r  = $urandom;
        if (lz == 32) return 32'h0;
        return (r >> lz) | (32'h8000_0000 >> lz);
    endfunction

    // Scoreboard: order, tags, no drops/duplicates, stability under stall.
    always @(negedge clk) begin
        if (rst || IN_flush) begin
            q.delete();
            prev_stall = 0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", 64'(OUT_valid), 64'd1);
                check("stall_hold",
                      64'({OUT_data, OUT_shamt, OUT_zero, OUT_tag}),
                      64'(prev_out));
            end
            if (OUT_valid && OUT_ready) begin
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL sb_extra: got tag %0h expected none",
                             OUT_tag);
                end else begin
                    e = q.pop_front();
                    check("sb_data", 64'(OUT_data), 64'(e.d));
                    check("sb_shamt", 64'(OUT_shamt), 64'(e.sh));
                    check("sb_zero", 64'(OUT_zero), 64'(e.z));
                    check("sb_tag", 64'(OUT_tag), 64'(e.tag));
                end
            end
            if (IN_valid && IN_ready)
                q.push_back(model(IN_data, IN_tag, IN_denorm,
                                  int'(IN_shamt)));
            prev_stall = OUT_valid && !OUT_ready;
            prev_out   = {OUT_data, OUT_shamt, OUT_zero, OUT_tag};
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] d, input logic [6:0] t,
                         input bit dn, input int ds);
        IN_valid  = 1'b1;
        IN_data   = d;
        IN_tag    = t;
        IN_denorm = 1'b0;
        IN_shamt  = 6'd0;
`ifdef LZN_DENORM_EN
        IN_denorm = dn;
        IN_shamt  = 6'(ds);
`endif
    endtask

    task automatic run_op(input vec_t v, input string nm);
        drive(v.d, v.t, v.dn, v.ds);
        OUT_ready = 1'b1;
        step();
        IN_valid = 1'b0;
        check({nm, "_c1_valid"}, 64'(OUT_valid), 64'd0);
        step();
        check({nm, "_valid"}, 64'(OUT_valid), 64'd1);
        check({nm, "_data"}, 64'(OUT_data), 64'(v.ed));
        check({nm, "_shamt"}, 64'(OUT_shamt), 64'(v.es));
        check({nm, "_zero"}, 64'(OUT_zero), 64'(v.ez));
        check({nm, "_tag"}, 64'(OUT_tag), 64'(v.t));
        step();
    endtask

    task automatic check_reset_state(input string nm);
        check({nm, "_valid"}, 64'(OUT_valid), 64'd0);
        check({nm, "_data"}, 64'(OUT_data), 64'd0);
        check({nm, "_shamt"}, 64'(OUT_shamt), 64'd0);
        check({nm, "_zero"}, 64'(OUT_zero), 64'd0);
        check({nm, "_tag"}, 64'(OUT_tag), 64'd0);
    endtask

    task automatic random_stream(input int cycles);
        accepted = 1'b1;
        for (int c = 0; c < cycles; c++) begin
            if (accepted || !IN_valid) begin
                drive(rnd_data(), 7'($urandom), 1'b0, 0);
                IN_valid = ($urandom_range(0, 3) != 0);
`ifdef LZN_DENORM_EN
                IN_denorm = ($urandom_range(0, 3) == 0);
                IN_shamt  = 6'($urandom_range(0, 40));
`endif
            end
            OUT_ready = ($urandom_range(0, 3) != 0);
            #1;
            accepted = IN_valid && IN_ready;
            step();
        end
    endtask

    initial begin
        vt.push_back('{32'h0000_0001, 7'd1, 0, 0, 32'h8000_0000, 31, 0});
        vt.push_back('{32'h0000_0000, 7'd2, 0, 0, 32'h0000_0000, 32, 1});
        vt.push_back('{32'h8000_0000, 7'd3, 0, 0, 32'h8000_0000, 0, 0});
        vt.push_back('{32'h00F0_0000, 7'd4, 0, 0, 32'hF000_0000, 8, 0});
        vt.push_back('{32'h0000_0F00, 7'd5, 0, 0, 32'hF000_0000, 20, 0});
        vt.push_back('{32'h1234_5678, 7'd6, 0, 0, 32'h91A2_B3C0, 3, 0});
        vt.push_back('{32'h4000_0000, 7'd7, 0, 0, 32'h8000_0000, 1, 0});
        vt.push_back('{32'h0000_FFFF, 7'h7F, 0, 0, 32'hFFFF_0000, 16, 0});
`ifdef LZN_DENORM_EN
        vt.push_back('{32'hF000_0000, 7'd8, 1, 8, 32'h00F0_0000, 8, 0});
        vt.push_back('{32'hF000_0000, 7'd9, 1, 32, 32'h0000_0000, 32, 1});
        vt.push_back('{32'h0000_0001, 7'd10, 1, 0, 32'h0000_0001, 0, 0});
`endif

        rst       = 1'b1;
        IN_flush  = 1'b0;
        IN_valid  = 1'b0;
        IN_data   = '0;
        IN_tag    = '0;
        IN_denorm = 1'b0;
        IN_shamt  = '0;
        OUT_ready = 1'b0;
        repeat (3) step();
        rst = 1'b0;
        check_reset_state("rst");
        check("rst_in_ready", 64'(IN_ready), 64'd1);

        foreach (vt[i]) run_op(vt[i], $sformatf("vec%0d", i));

        // Two ops back to back, output stalled for three cycles.
        OUT_ready = 1'b0;
        drive(32'h00F0_0000, 7'd3, 0, 0);
        step();
        drive(32'h0000_0F00, 7'd4, 0, 0);
        check("stall_accept_b", 64'(IN_ready), 64'd1);
        step();
        IN_valid = 1'b0;
        check("stall_in_ready", 64'(IN_ready), 64'd0);
        snap = {OUT_data, OUT_shamt, OUT_zero, OUT_tag};
        repeat (2) begin
            step();
            check("stall_in_ready_hold", 64'(IN_ready), 64'd0);
            check("stall_out_stable",
                  64'({OUT_data, OUT_shamt, OUT_zero, OUT_tag}), 64'(snap));
        end
        OUT_ready = 1'b1;
        check("order_a", 64'({OUT_valid, OUT_data, OUT_shamt, OUT_tag}),
              64'({1'b1, 32'hF000_0000, 6'd8, 7'd3}));
        step();
        check("order_b", 64'({OUT_valid, OUT_data, OUT_shamt, OUT_tag}),
              64'({1'b1, 32'hF000_0000, 6'd20, 7'd4}));
        step();
        check("order_empty", 64'(OUT_valid), 64'd0);

        // Flush with both stages full and a new op offered.
        OUT_ready = 1'b0;
        drive(32'h0000_0010, 7'd10, 0, 0);
        step();
        drive(32'h0000_0020, 7'd11, 0, 0);
        step();
        drive(32'h0000_0040, 7'd12, 0, 0);
        OUT_ready = 1'b1;
        IN_flush  = 1'b1;
        step();
        IN_flush = 1'b0;
        IN_valid = 1'b0;
        check("flush_out_valid", 64'(OUT_valid), 64'd0);
        check("flush_in_ready", 64'(IN_ready), 64'd1);
        step();
        check("flush_none_1", 64'(OUT_valid), 64'd0);
        step();
        check("flush_none_2", 64'(OUT_valid), 64'd0);

        random_stream(1500);

        // Reset in the middle of the stream.
        rst = 1'b1;
        step();
        rst = 1'b0;
        IN_valid = 1'b0;
        check_reset_state("midrst");
        check("midrst_in_ready", 64'(IN_ready), 64'd1);
        run_op(vt[5], "post_rst");

        random_stream(1500);

        IN_valid  = 1'b0;
        OUT_ready = 1'b1;
        for (int i = 0; i < 20 && q.size() != 0; i++) step();
        check("drain_empty", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
